odeme_hakem: RTL

- Round-robin controller that shares one `odeme` payment unit among N requesters (card readers/turnstiles).
- Grants one requester at a time and captures its balance and fare.
- Sequences the unit's `basla`/`bitti` exchange, then returns the approve flag and new balance to the granted requester as a one-cycle response.
- Adds a timeout guard and an approved-payment counter.

---
 rtl/odeme_pkg.sv | 20 ++
 rtl/rr_hakem.sv | 40 ++++
 rtl/odeme_hakem.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/odeme_pkg.sv
// Shared definitions for the payment arbiter (odeme_hakem) and the
// payment unit it drives.
//   UCRET_W  : fare width carried to/from the payment unit.
//   BAKIYE_W : card balance width carried to/from the payment unit.
//   durum_e  : arbiter control states.
//     Bosta : idle, waiting for a request.
//     Islem : start pulse to the unit.
//     Bekle : waiting for done or timeout.
package odeme_pkg;

  localparam int unsigned UCRET_W  = 8;
  localparam int unsigned BAKIYE_W = 9;

  typedef enum logic [1:0] {
    Bosta = 2'd0,
    Islem = 2'd1,
    Bekle = 2'd2
  } durum_e;

endpackage

// File: rtl/rr_hakem.sv
// Combinational round-robin picker.
// The search starts at the requester selected by ptr_i and moves upward,
// wrapping past N-1. The first requester found with its bit set wins.
//   istek_i : per-requester request levels.
//   ptr_i   : requester that has highest priority this round.
//   grant_o : one-hot grant (all zero when nobody requests).
//   idx_o   : binary index of the granted requester.
//   any_o   : at least one request present.
module rr_hakem #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    istek_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    int unsigned aday;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    aday    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr_i < N and k < N, so one subtraction is enough to wrap.
      aday = 32'(ptr_i) + k;
      if (aday >= N) begin
        aday = aday - N;
      end
      if (!any_o && istek_i[aday]) begin
        any_o         = 1'b1;
        idx_o         = IdxW'(aday);
        grant_o[aday] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/odeme_hakem.sv
// Round-robin controller that shares one payment unit among N requesters.
// A requester is granted in Bosta, and its fare and balance are latched.
// The block then pulses o_basla and waits for o_bitti. The unit's verdict
// goes back to the granted requester as a one-cycle cevap_gecerli strobe.
// If the unit does not answer within ZAMAN_ASIMI cycles, the requester gets
// an error response that returns its original balance.
//   saat, reset           : clock (rising edge), async active-low reset.
//   istek                 : per-requester request levels.
//   ucret_in, bakiye_in   : packed per-requester fare / balance.
//   o_basla, o_ucret,
//   o_bakiye              : start pulse and operands to the payment unit.
//   o_onay, o_k_bakiye,
//   o_bitti               : verdict, remaining balance and done pulse from
//                           the unit.
//   cevap_gecerli         : one-hot response strobe.
//   cevap_onay/hata/bakiye: response data, held until the next response.
//   mesgul                : transaction in flight.
//   onay_sayac            : saturating count of approved payments.
module odeme_hakem
  import odeme_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned ZAMAN_ASIMI = 8,
  parameter int unsigned SAYAC_W     = 16
) (
  input  logic                  saat,
  input  logic                  reset,
  input  logic [N-1:0]          istek,
  input  logic [UCRET_W*N-1:0]  ucret_in,
  input  logic [BAKIYE_W*N-1:0] bakiye_in,
  output logic                  o_basla,
  output logic [UCRET_W-1:0]    o_ucret,
  output logic [BAKIYE_W-1:0]   o_bakiye,
  input  logic                  o_onay,
  input  logic [BAKIYE_W-1:0]   o_k_bakiye,
  input  logic                  o_bitti,
  output logic [N-1:0]          cevap_gecerli,
  output logic                  cevap_onay,
  output logic                  cevap_hata,
  output logic [BAKIYE_W-1:0]   cevap_bakiye,
  output logic                  mesgul,
  output logic [SAYAC_W-1:0]    onay_sayac
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ZamW = $clog2(ZAMAN_ASIMI + 1);

  durum_e                durum_q, durum_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [N-1:0]          grant_q, grant_d;
  logic [UCRET_W-1:0]    ucret_q, ucret_d;
  logic [BAKIYE_W-1:0]   bakiye_q, bakiye_d;
  logic [ZamW-1:0]       zaman_q, zaman_d;
  logic [N-1:0]          cevap_gecerli_q, cevap_gecerli_d;
  logic                  cevap_onay_q, cevap_onay_d;
  logic                  cevap_hata_q, cevap_hata_d;
  logic [BAKIYE_W-1:0]   cevap_bakiye_q, cevap_bakiye_d;
  logic [SAYAC_W-1:0]    onay_sayac_q, onay_sayac_d;
  logic                  bitir;

  logic [N-1:0]          rr_grant;
  logic [IdxW-1:0]       rr_idx;
  logic                  rr_any;

  rr_hakem #(
    .N    (N),
    .IdxW (IdxW)
  ) u_rr_hakem (
    .istek_i (istek),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  always_comb begin
    durum_d         = durum_q;
    ptr_d           = ptr_q;
    idx_d           = idx_q;
    grant_d         = grant_q;
    ucret_d         = ucret_q;
    bakiye_d        = bakiye_q;
    zaman_d         = zaman_q;
    cevap_gecerli_d = '0;
    cevap_onay_d    = cevap_onay_q;
    cevap_hata_d    = cevap_hata_q;
    cevap_bakiye_d  = cevap_bakiye_q;
    onay_sayac_d    = onay_sayac_q;
    bitir           = 1'b0;

    unique case (durum_q)
      Bosta: begin
        // A stray o_bitti here is deliberately ignored.
        if (rr_any) begin
          idx_d    = rr_idx;
          grant_d  = rr_grant;
          ucret_d  = ucret_in[32'(rr_idx) * UCRET_W +: UCRET_W];
          bakiye_d = bakiye_in[32'(rr_idx) * BAKIYE_W +: BAKIYE_W];
          durum_d  = Islem;
        end
      end
      Islem: begin
        zaman_d = '0;
        durum_d = Bekle;
      end
      Bekle: begin
        if (o_bitti) begin
          cevap_onay_d   = o_onay;
          cevap_bakiye_d = o_k_bakiye;
          cevap_hata_d   = 1'b0;
          bitir          = 1'b1;
        end else if (zaman_q == ZamW'(ZAMAN_ASIMI - 1)) begin
          // Unit never answered; hand the card its untouched balance back.
          cevap_onay_d   = 1'b0;
          cevap_bakiye_d = bakiye_q;
          cevap_hata_d   = 1'b1;
          bitir          = 1'b1;
        end else begin
          zaman_d = zaman_q + ZamW'(1);
        end
      end
      default: begin
        durum_d = Bosta;
      end
    endcase

    if (bitir) begin
      cevap_gecerli_d = grant_q;
      ptr_d           = (32'(idx_q) == N - 1) ? '0 : idx_q + IdxW'(1);
      zaman_d         = '0;
      durum_d         = Bosta;
      if (cevap_onay_d && (onay_sayac_q != '1)) begin
        onay_sayac_d = onay_sayac_q + SAYAC_W'(1);
      end
    end
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q         <= Bosta;
      ptr_q           <= '0;
      idx_q           <= '0;
      grant_q         <= '0;
      ucret_q         <= '0;
      bakiye_q        <= '0;
      zaman_q         <= '0;
      cevap_gecerli_q <= '0;
      cevap_onay_q    <= 1'b0;
      cevap_hata_q    <= 1'b0;
      cevap_bakiye_q  <= '0;
      onay_sayac_q    <= '0;
    end else begin
      durum_q         <= durum_d;
      ptr_q           <= ptr_d;
      idx_q           <= idx_d;
      grant_q         <= grant_d;
      ucret_q         <= ucret_d;
      bakiye_q        <= bakiye_d;
      zaman_q         <= zaman_d;
      cevap_gecerli_q <= cevap_gecerli_d;
      cevap_onay_q    <= cevap_onay_d;
      cevap_hata_q    <= cevap_hata_d;
      cevap_bakiye_q  <= cevap_bakiye_d;
      onay_sayac_q    <= onay_sayac_d;
    end
  end

  // Operands stay on the latched values for the whole exchange.
  assign o_basla       = (durum_q == Islem);
  assign o_ucret       = ucret_q;
  assign o_bakiye      = bakiye_q;
  assign mesgul        = (durum_q == Islem) || (durum_q == Bekle);
  assign cevap_gecerli = cevap_gecerli_q;
  assign cevap_onay    = cevap_onay_q;
  assign cevap_hata    = cevap_hata_q;
  assign cevap_bakiye  = cevap_bakiye_q;
  assign onay_sayac    = onay_sayac_q;

endmodule
